// File: rtl/hack_rom_loader_if.sv
// Word-stream input and ROM write port of the Hack program loader.
// The master side feeds framed words and observes the ROM writes; the slave side is the loader.
interface hack_rom_loader_if #(
  parameter int ADDR_W = 15
);
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Hack program loader: takes a length/words/checksum frame, writes the instruction ROM,
// optionally zero-fills the remainder, and holds the CPU in reset until a good load completes.
module hack_rom_loader #(
  parameter int ADDR_W    = 15,
  parameter bit FILL_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  hack_rom_loader_if.slave   bus,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, FILL, RUN, ERR} state_t;

  // The counter carries one extra bit so a full-depth frame (N = 2^ADDR_W) does not wrap.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic [ADDR_W:0]   n_words, n_nx;
  logic [15:0]       sum, sum_nx;
  logic [15:0]       loaded_nx;
  logic              accept;
  logic              hdr_too_big;

  assign accept      = bus.in_valid && bus.in_ready;
  assign hdr_too_big = {1'b0, bus.in_data} > 17'(DEPTH);

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    n_nx          = n_words;
    sum_nx        = sum;
    loaded_nx     = words_loaded;
    bus.in_ready  = 1'b0;
    bus.rom_we    = 1'b0;
    bus.rom_addr  = cnt[ADDR_W-1:0];
    bus.rom_wdata = '0;

    case (state)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_nx  = HDR;
          cnt_nx    = '0;
          sum_nx    = '0;
          loaded_nx = '0;
        end
      end

      HDR: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          n_nx = bus.in_data[ADDR_W:0];
          if (hdr_too_big)
            state_nx = ERR;
          else if (bus.in_data == 16'h0000)
            state_nx = CSUM;
          else
            state_nx = DATA;
        end
      end

      DATA: begin
        bus.in_ready  = 1'b1;
        bus.rom_we    = accept;
        bus.rom_wdata = bus.in_data;
        if (accept) begin
          cnt_nx    = cnt + 1'b1;
          sum_nx    = sum + bus.in_data;
          loaded_nx = words_loaded + 16'd1;
          if (cnt_nx == n_words)
            state_nx = CSUM;
        end
      end

      CSUM: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          if (bus.in_data != sum)
            state_nx = ERR;
          else if (!FILL_ZERO || cnt == DEPTH)
            state_nx = RUN;
          else
            state_nx = FILL;
        end
      end

      FILL: begin
        bus.rom_we = 1'b1;
        cnt_nx     = cnt + 1'b1;
        if (cnt == LAST)
          state_nx = RUN;
      end

      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are derived from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      n_words      <= '0;
      sum          <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      n_words      <= n_nx;
      sum          <= sum_nx;
      words_loaded <= loaded_nx;
      cpu_reset    <= (state_nx != RUN);
      busy         <= (state_nx == HDR) || (state_nx == DATA) ||
                      (state_nx == CSUM) || (state_nx == FILL);
      done         <= (state_nx == RUN) && (state != RUN);
      error        <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Randomized and directed frames for hack_rom_loader (ADDR_W=4, FILL_ZERO=1), checked against
// a frame-level model of the expected ROM writes, final image and status outputs.
module tb_hack_rom_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_reset, busy, done, error;
  logic [15:0] words_loaded;

  hack_rom_loader_if #(.ADDR_W(AW)) bus ();

  hack_rom_loader #(.ADDR_W(AW), .FILL_ZERO(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          checkCount = 0;
  int          passCount  = 0;
  int          cycleNum   = 0;
  int          doneCount  = 0;
  int          doneCyc    = -1;
  int          startCyc   = 0;
  logic [15:0] payload[$];
  logic [19:0] writeLog[$];
  logic [15:0] tbRom[DEPTH];
  logic [15:0] modelRom[DEPTH];

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Observe the ROM port and done away from the active edge.
  always @(negedge clk) begin
    if (bus.rom_we) begin
      writeLog.push_back({bus.rom_addr, bus.rom_wdata});
      tbRom[bus.rom_addr] = bus.rom_wdata;
    end
    if (done) begin
      doneCount++;
      if (doneCyc < 0) doneCyc = cycleNum;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " cpu_reset"}, 32'(cpu_reset), 1);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " error"}, 32'(error), 0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 0);
    checkOutput({tag, " rom_we"}, 32'(bus.rom_we), 0);
    checkOutput({tag, " rom_addr"}, 32'(bus.rom_addr), 0);
    checkOutput({tag, " rom_wdata"}, 32'(bus.rom_wdata), 0);
    checkOutput({tag, " words_loaded"}, 32'(words_loaded), 0);
  endtask

  task automatic pushWord(input logic [15:0] w, input bit stall);
    logic acc;
    if (stall) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    checkOutput("handshake timeout", 0, 1);
  endtask

  task automatic sendStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    startCyc = cycleNum;
  endtask

  // One complete frame: header n, the words in payload, then csum; stall inserts an idle cycle per word.
  task automatic applyStimulus(input int n, input logic [15:0] csum, input bit stall, input bit checkLatency);
    logic [19:0] expW[$];
    logic [15:0] sum;
    bit          hdrBad, good, seen;
    int          mism;

    writeLog.delete();
    doneCount = 0;
    doneCyc   = -1;
    sendStart();
    checkOutput("after start busy", 32'(busy), 1);
    checkOutput("after start error", 32'(error), 0);
    checkOutput("after start cpu_reset", 32'(cpu_reset), 1);

    hdrBad = (n > DEPTH);
    pushWord(16'(n), 1'b0);
    if (!hdrBad) begin
      for (int i = 0; i < n; i++) pushWord(payload[i], stall);
      pushWord(csum, stall);
    end
    bus.in_valid = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      seen = done || error;
    end
    if (!seen) checkOutput("outcome timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;

    sum = 16'h0000;
    for (int i = 0; i < n && !hdrBad; i++) sum = sum + payload[i];
    good = !hdrBad && (csum == sum);
    if (!hdrBad)
      for (int i = 0; i < n; i++) expW.push_back({4'(i), payload[i]});
    if (good)
      for (int a = n; a < DEPTH; a++) expW.push_back({4'(a), 16'h0000});
    foreach (expW[i]) modelRom[expW[i][19:16]] = expW[i][15:0];

    checkOutput("write count", 32'(writeLog.size()), 32'(expW.size()));
    mism = 0;
    for (int i = 0; i < expW.size() && i < writeLog.size(); i++)
      if (writeLog[i] !== expW[i]) mism++;
    checkOutput("write sequence", 32'(mism), 0);
    mism = 0;
    for (int a = 0; a < DEPTH; a++)
      if (tbRom[a] !== modelRom[a]) mism++;
    checkOutput("rom image", 32'(mism), 0);
    checkOutput("done pulses", 32'(doneCount), good ? 1 : 0);
    checkOutput("cpu_reset", 32'(cpu_reset), good ? 0 : 1);
    checkOutput("error", 32'(error), good ? 0 : 1);
    checkOutput("busy", 32'(busy), 0);
    checkOutput("words_loaded", 32'(words_loaded), hdrBad ? 0 : 32'(n));
    if (checkLatency && good)
      checkOutput("start to done cycles", 32'(doneCyc - startCyc + 1), 32'(1 + (n + 2) + (DEPTH - n)));
  endtask

  initial begin
    int          n;
    logic [15:0] s, c;
    bit          bad, stall;

    for (int a = 0; a < DEPTH; a++) begin
      tbRom[a]    = 16'hDEAD;
      modelRom[a] = 16'hDEAD;
    end
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    #1;
    checkResetState("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] good frame with fill");
    payload = '{16'h0001, 16'h0002, 16'h0003};
    applyStimulus(3, 16'h0006, 1'b0, 1'b1);

    $display("[TB] bad checksum");
    applyStimulus(3, 16'h0007, 1'b0, 1'b0);

    $display("[TB] oversized header");
    applyStimulus(17, 16'h0000, 1'b0, 1'b0);

    $display("[TB] checksum wrap");
    payload = '{16'hFFFF, 16'h0002};
    applyStimulus(2, 16'h0001, 1'b0, 1'b1);
    c = 16'(17'h10001);
    applyStimulus(2, c, 1'b0, 1'b0);
    applyStimulus(2, 16'h0000, 1'b0, 1'b0);

    $display("[TB] backpressure");
    payload = '{16'h0001, 16'h0002, 16'h0003};
    applyStimulus(3, 16'h0006, 1'b1, 1'b0);

    $display("[TB] reset during data");
    payload = '{16'h1111, 16'h2222, 16'h3333};
    writeLog.delete();
    sendStart();
    pushWord(16'd3, 1'b0);
    pushWord(payload[0], 1'b0);
    pushWord(payload[1], 1'b0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checkResetState("mid-load reset");
    modelRom[0] = payload[0];
    modelRom[1] = payload[1];
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(3, 16'h6666, 1'b0, 1'b1);

    $display("[TB] random frames");
    for (int t = 0; t < 14; t++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 40)) : int'($urandom_range(0, 16));
      payload.delete();
      s = 16'h0000;
      for (int i = 0; i < n && n <= DEPTH; i++) begin
        payload.push_back(16'($urandom));
        s = s + payload[i];
      end
      bad   = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 1) == 1);
      c     = bad ? (s ^ 16'(1 << $urandom_range(0, 15))) : s;
      applyStimulus(n, c, stall, !stall);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
